// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared sizes and FSM encoding for the data memory arbiter
package dmem_pkg;
    localparam int MEM_BYTES = 1024;
    localparam int WORD_BYTES = 4;
    localparam int MAX_WORD_ADDR = MEM_BYTES - WORD_BYTES;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick with the last-granted register
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic win
);
    logic last_gnt;
    always_comb win = (req0 && req1) ? !last_gnt : req1;
    // reset to port 1 so port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) last_gnt <= 1'b1;
        else if (take) last_gnt <= win;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two requesters onto the single-port data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              err0,
    output logic              err1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    // highest address whose 4-byte word still fits without wrapping
    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(2 ** ADDR_W - WORD_BYTES);
    state_t state;
    logic [2:0] cnt;
    logic cmd_port, cmd_rd;
    logic win, w_we, w_ok;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    rr_arb2 u_arb (
        .clk  (clk),
        .reset(reset),
        .req0 (req0),
        .req1 (req1),
        .take (state == IDLE && (req0 || req1)),
        .win  (win)
    );
    always_comb begin
        w_we = win ? we1 : we0;
        w_addr = win ? addr1 : addr0;
        w_wdata = win ? wdata1 : wdata0;
        w_ok = w_addr <= MAX_A;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            cmd_port <= 1'b0;
            cmd_rd <= 1'b0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            mem_enable <= 1'b0;
            mem_rw <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_enable <= 1'b0;
            mem_rw <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: if (req0 || req1) begin
                    state <= ISSUE;
                    cmd_port <= win;
                    cmd_rd <= w_ok && !w_we;
                    gnt0 <= !win;
                    gnt1 <= win;
                    err0 <= !win && !w_ok;
                    err1 <= win && !w_ok;
                    mem_enable <= w_ok;
                    mem_rw <= w_ok && w_we;
                    mem_addr <= w_ok ? w_addr : '0;
                    mem_wdata <= w_ok ? w_wdata : '0;
                end
                ISSUE: begin
                    state <= cmd_rd ? WAIT_RD : IDLE;
                    cnt <= 3'(RD_LAT);
                end
                WAIT_RD: if (cnt == '0) state <= IDLE;
                else begin
                    cnt <= cnt - 3'd1;
                    // last wait cycle: data is valid on mem_rdata now
                    if (cnt == 3'd1) begin
                        rvalid0 <= !cmd_port;
                        rvalid1 <= cmd_port;
                        if (cmd_port) rdata1 <= mem_rdata;
                        else rdata0 <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter instances (RD_LAT 1 and 3) checked against a transaction-level model
module tb_dmem_arbiter;
    import dmem_pkg::*;
    localparam int LAT [2] = '{1, 3};
    typedef struct {
        logic we;
        logic [9:0] addr;
        logic [31:0] wdata;
    } cmd_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;
    logic req0 [2], req1 [2], we0 [2], we1 [2];
    logic [9:0] addr0 [2], addr1 [2], mem_addr [2];
    logic [31:0] wdata0 [2], wdata1 [2], rdata0 [2], rdata1 [2], mem_wdata [2];
    logic gnt0 [2], gnt1 [2], err0 [2], err1 [2], rvalid0 [2], rvalid1 [2];
    logic mem_enable [2], mem_rw [2];
    logic [7:0] ref_mem [2][MEM_BYTES];
    int errors = 0, checks = 0;

    function automatic logic [7:0] init_byte(int g, int i);
        logic [31:0] w;
        w = 32'h99127254;
        if (i >= 4 && i < 8) return w[8*(i-4) +: 8];
        return 8'(i * 37 + g * 91 + 5);
    endfunction

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gi
            localparam int L = LAT[g];
            logic [7:0] dev [MEM_BYTES];
            logic [31:0] pipe [L];
            logic [31:0] mrd;
            assign mrd = pipe[L-1];
            dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(L)) dut (
                .clk(clk), .reset(reset),
                .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
                .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
                .gnt0(gnt0[g]), .gnt1(gnt1[g]), .err0(err0[g]), .err1(err1[g]),
                .rvalid0(rvalid0[g]), .rvalid1(rvalid1[g]), .rdata0(rdata0[g]), .rdata1(rdata1[g]),
                .mem_enable(mem_enable[g]), .mem_rw(mem_rw[g]), .mem_addr(mem_addr[g]),
                .mem_wdata(mem_wdata[g]), .mem_rdata(mrd)
            );
            initial for (int i = 0; i < MEM_BYTES; i++) dev[i] = init_byte(g, i);
            // memory device: words little-endian, read data appears L cycles after the command
            always @(posedge clk) begin
                logic [31:0] w;
                for (int k = 0; k < 4; k++) w[8*k +: 8] = dev[mem_addr[g] + 10'(k)];
                if (mem_enable[g] === 1'b1 && mem_rw[g] === 1'b1)
                    for (int k = 0; k < 4; k++) dev[mem_addr[g] + 10'(k)] <= mem_wdata[g][8*k +: 8];
                pipe[0] <= (mem_enable[g] === 1'b1 && mem_rw[g] === 1'b0) ? w : $urandom;
                for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            end
        end
    endgenerate

    // reference model state: one outstanding transaction, times in cycles
    int a, cyc, free_at, g_cyc, rv_cyc;
    bit last, g_port, g_err, g_we, rv_port, after_reset;
    logic [9:0] g_addr;
    logic [31:0] g_wdata, rv_data;
    logic [31:0] exp_rd [2];
    cmd_t q0[$], q1[$];
    int ord[$];
    int gc [2], rc [2], ec [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d inst=%0d", tag, obs, exp, cyc, a);
        end
    endtask

    task automatic tick();
        bit r0, r1;
        if (reset) begin
            after_reset = 1;
            free_at = cyc + 1;
            last = 1;
            g_cyc = -1;
            rv_cyc = -1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            after_reset = 0;
            r0 = req0[a];
            r1 = req1[a];
            if (cyc >= free_at && (r0 || r1)) begin
                g_port = (r0 && r1) ? !last : r1;
                last = g_port;
                g_cyc = cyc + 1;
                g_we = g_port ? we1[a] : we0[a];
                g_addr = g_port ? addr1[a] : addr0[a];
                g_wdata = g_port ? wdata1[a] : wdata0[a];
                g_err = int'(g_addr) > MAX_WORD_ADDR;
                if (g_err || g_we) free_at = cyc + 2;
                else begin
                    rv_cyc = cyc + LAT[a] + 2;
                    rv_port = g_port;
                    for (int k = 0; k < 4; k++) rv_data[8*k +: 8] = ref_mem[a][g_addr + 10'(k)];
                    free_at = cyc + LAT[a] + 3;
                end
                if (!g_err && g_we)
                    for (int k = 0; k < 4; k++) ref_mem[a][g_addr + 10'(k)] = g_wdata[8*k +: 8];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rv_cyc == cyc) exp_rd[rv_port] = rv_data;
        chk("gnt0", gnt0[a], g_cyc == cyc && !g_port);
        chk("gnt1", gnt1[a], g_cyc == cyc && g_port);
        chk("err0", err0[a], g_cyc == cyc && g_err && !g_port);
        chk("err1", err1[a], g_cyc == cyc && g_err && g_port);
        chk("rvalid0", rvalid0[a], rv_cyc == cyc && !rv_port);
        chk("rvalid1", rvalid1[a], rv_cyc == cyc && rv_port);
        chk("mem_enable", mem_enable[a], g_cyc == cyc && !g_err);
        if (g_cyc == cyc && !g_err) begin
            chk("mem_rw", mem_rw[a], g_we);
            chk("mem_addr", mem_addr[a], g_addr);
            chk("mem_wdata", mem_wdata[a], g_wdata);
        end
        if (after_reset) begin
            chk("rst_mem_rw", mem_rw[a], 0);
            chk("rst_mem_addr", mem_addr[a], 0);
            chk("rst_mem_wdata", mem_wdata[a], 0);
        end
        chk("rdata0", rdata0[a], exp_rd[0]);
        chk("rdata1", rdata1[a], exp_rd[1]);
    endtask

    task automatic cycle();
        for (int i = 0; i < 2; i++) begin
            req0[i] = 0; req1[i] = 0; we0[i] = 0; we1[i] = 0;
            addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
        end
        if (q0.size() > 0) begin
            req0[a] = 1; we0[a] = q0[0].we; addr0[a] = q0[0].addr; wdata0[a] = q0[0].wdata;
        end
        if (q1.size() > 0) begin
            req1[a] = 1; we1[a] = q1[0].we; addr1[a] = q1[0].addr; wdata1[a] = q1[0].wdata;
        end
        tick();
        if (gnt0[a] === 1'b1) begin
            gc[0] = cyc;
            ord.push_back(0);
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (gnt1[a] === 1'b1) begin
            gc[1] = cyc;
            ord.push_back(1);
            if (q1.size() > 0) void'(q1.pop_front());
        end
        if (err0[a] === 1'b1) ec[0] = cyc;
        if (err1[a] === 1'b1) ec[1] = cyc;
        if (rvalid0[a] === 1'b1) rc[0] = cyc;
        if (rvalid1[a] === 1'b1) rc[1] = cyc;
    endtask

    task automatic clear_marks();
        gc = '{-1, -1};
        rc = '{-1, -1};
        ec = '{-1, -1};
        ord.delete();
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", q0.size() + q1.size(), 0);
        repeat (8) cycle();
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    function automatic cmd_t mk(logic we, logic [9:0] addr, logic [31:0] wdata);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        c.wdata = wdata;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        logic [9:0] ad;
        ad = ($urandom_range(0, 4) == 0) ? 10'(1018 + $urandom_range(0, 5)) : 10'($urandom_range(0, 1023));
        return mk(1'($urandom_range(0, 1)), ad, $urandom);
    endfunction

    task automatic random_run(int n);
        repeat (n) begin
            if (q0.size() < 2 && $urandom_range(0, 2) != 0) q0.push_back(rnd_cmd());
            if (q1.size() < 2 && $urandom_range(0, 2) != 0) q1.push_back(rnd_cmd());
            cycle();
        end
        drain(200);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < MEM_BYTES; j++) ref_mem[i][j] = init_byte(i, j);
        a = 0;
        cyc = 0;
        do_reset();

        clear_marks();
        n = cyc;
        q0.push_back(mk(1, 10'h008, 32'hDEADBEEF));
        drain(20);
        chk("wr_gnt_lat", 32'(gc[0] - n), 1);

        clear_marks();
        n = cyc;
        q1.push_back(mk(0, 10'h004, 32'h0));
        drain(20);
        chk("rd_gnt_lat", 32'(gc[1] - n), 1);
        chk("rd_rvalid_lat", 32'(rc[1] - n), 3);
        chk("rd_rdata_hold", rdata1[a], 32'h99127254);

        clear_marks();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'(i % 2), 10'(16 * i + 64), $urandom));
            q1.push_back(mk(1'(1 - i % 2), 10'(16 * i + 512), $urandom));
        end
        drain(60);
        chk("fair_count", ord.size(), 8);
        for (int i = 0; i < ord.size() && i < 8; i++) chk("fair_order", ord[i], i % 2);

        clear_marks();
        n = cyc;
        q0.push_back(mk(0, 10'h3FD, 32'h0));
        drain(20);
        chk("oor_err_with_gnt", 32'(ec[0]), 32'(gc[0]));
        chk("oor_err_lat", 32'(ec[0] - n), 1);
        chk("oor_no_rvalid", 32'(rc[0]), 32'hFFFF_FFFF);
        clear_marks();
        n = cyc;
        q0.push_back(mk(0, 10'h3FC, 32'h0));
        drain(20);
        chk("top_no_err", 32'(ec[0]), 32'hFFFF_FFFF);
        chk("top_rvalid_lat", 32'(rc[0] - n), 3);

        random_run(400);

        a = 1;
        do_reset();
        clear_marks();
        n = cyc;
        q0.push_back(mk(0, 10'h004, 32'h0));
        q1.push_back(mk(1, 10'h080, 32'hCAFEF00D));
        drain(30);
        chk("l3_gnt0_lat", 32'(gc[0] - n), 1);
        chk("l3_rvalid0_lat", 32'(rc[0] - n), 5);
        chk("l3_gnt1_lat", 32'(gc[1] - n), 7);
        chk("l3_rdata0", rdata0[a], 32'h99127254);

        clear_marks();
        q0.push_back(mk(0, 10'h040, 32'h0));
        n = 0;
        while (gc[0] < 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("rst_gnt_seen", 32'(gc[0] >= 0), 1);
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        repeat (8) cycle();
        chk("rst_no_rvalid", 32'(rc[0]), 32'hFFFF_FFFF);
        clear_marks();
        q0.push_back(mk(1, 10'h100, 32'h1));
        q1.push_back(mk(1, 10'h104, 32'h2));
        drain(20);
        chk("rst_tie_port0", ord.size() > 0 ? ord[0] : 9, 0);

        random_run(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed 1 KiB data memory.
- The memory stores words little-endian across 4 bytes, has a single port, and takes an enable and a read/write command.
- Port 0 is the CPU load/store unit. Port 1 is the program/data loader (DMA/debug).
- The block serialises accesses with round-robin priority, rejects word accesses that run past the top of memory, and returns read data with a valid pulse.

Parameters:
- ADDR_W, 10, byte address width; memory holds 2**ADDR_W bytes.
- DATA_W, 32, word width; fixed at 4 bytes per access.
- RD_LAT, 1, cycles from the memory read command to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, port 0 / port 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  byte address of the lowest byte.
- wdata0 / wdata1  in  DATA_W  write word.
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted.
- err0 / err1  out  1  one-cycle pulse, coincident with gnt: command rejected (out of range).
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid.
- rdata0 / rdata1  out  DATA_W  read word; holds its value until the next rvalid on that port.
- mem_enable  out  1  memory command strobe.
- mem_rw  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write word.
- mem_rdata  in  DATA_W  memory read word.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, last_gnt = 1 (so port 0 wins the first tie), latency counter 0.
  - Reset mid-read drops the read: no rvalid is issued.
  - Reset has priority over any request in the same cycle.
- FSM has three states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any req is high, select a winner and register its command (we, addr, wdata, port id); next state is ISSUE.
  - Single requester: that requester wins.
  - Both requesting: the port opposite last_gnt wins; last_gnt is updated to the winner.
- ISSUE (exactly one cycle): the gnt of the winning port is pulsed.
  - In range (addr <= 2**ADDR_W - 4):
    - mem_enable=1, mem_rw=we, mem_addr=addr, mem_wdata=wdata.
    - Write: next state IDLE.
    - Read: load counter = RD_LAT; next state WAIT_RD.
  - Out of range (addr > 2**ADDR_W - 4, i.e. addr+3 would wrap):
    - mem_enable=0; err pulsed together with gnt.
    - No memory access and no rvalid; next state IDLE.
- WAIT_RD:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture mem_rdata into rdataX of the owning port, pulse rvalidX, and go to IDLE.
  - Requests arriving in this state wait.
- Outputs: mem_* are registered; mem_enable is high only in ISSUE.
- Requester protocol:
  - Hold req and the command stable until gnt is seen.
  - Deassert req or present a new command in the cycle after gnt.
  - Behaviour is undefined if the command changes while req is high and gnt has not yet arrived.
- Latency, request seen in IDLE at cycle N:
  - gnt and the memory command at N+1.
  - Write: the next arbitration is at N+2.
  - Read: rvalid at N+1+RD_LAT+1; the next arbitration is on the following cycle.
- Alignment: addresses need not be word-aligned; they are forwarded unmodified. Only the range check applies.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1.

Decomposition:
- Shared package dmem_pkg holds:
  - MEM_BYTES = 1024, WORD_BYTES = 4;
  - the state encoding (IDLE, ISSUE, WAIT_RD);
  - the helper constant MAX_WORD_ADDR = MEM_BYTES - WORD_BYTES.
- One natural sub-module, rr_arb2: 2-way round-robin pick plus the last_gnt register. The FSM and datapath stay in dmem_arbiter.

Test Plan:
- After reset, req0 write addr=0x008 wdata=0xDEADBEEF at cycle N -> gnt0=1 and mem_enable=1, mem_rw=1, mem_addr=0x008, mem_wdata=0xDEADBEEF at N+1; IDLE at N+2.
- Read with RD_LAT=1, memory model preloaded addr=0x004 -> 0x99127254; req1 read 0x004 -> gnt1 at N+1, rvalid1 at N+3 with rdata1=0x99127254; rdata1 holds afterwards.
- req0 and req1 both held high for 8 accesses -> grant order 0,1,0,1,0,1,0,1; no gnt is issued during WAIT_RD.
- req0 read addr=0x3FD -> gnt0=err0=1 in the same cycle, mem_enable stays 0, no rvalid0. addr=0x3FC -> normal access.
- Reset asserted in WAIT_RD -> no rvalid; all outputs 0 next cycle. A subsequent tie is won by port 0.
- RD_LAT=3 with a stalled req1 write during a port-0 read -> rvalid0 at N+5; gnt1 at N+7 with the write issued.
